// File: rtl/dac_pkg.sv
// Shared types and frame layout for the MCP4911-class DAC serializer.
// The LDAC state exists only when DAC_LDAC_EN is defined.
package dac_pkg;

    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned DATA_W   = 10;
    localparam int unsigned CH       = 15;
    localparam int unsigned BUF      = 14;
    localparam int unsigned GA       = 13;
    localparam int unsigned SHDN     = 12;
    localparam int unsigned DATA_LSB = 2;

`ifdef DAC_LDAC_EN
    typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, LDAC} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, SHIFT, STOP} state_t;
`endif

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              buf_en,
        input logic              ga_n,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f                    = '0;
        f[CH]                = 1'b0;
        f[BUF]               = buf_en;
        f[GA]                = ga_n;
        f[SHDN]              = 1'b1;
        f[DATA_LSB +: DATA_W] = data;
        return f;
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Restartable divider: one-cycle tick every CLK_DIV sysclk cycles, counted
// from the last restart.
module dac_tick_gen #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Left ungated by restart: restart is derived from tick via next-state.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/dac_spi_serializer.sv
// SPI mode-0 frame serializer for an MCP4911-class DAC.
// Optional macro DAC_LDAC_EN adds an LDAC pulse after CS rises.
module dac_spi_serializer
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 16,
    parameter logic        DAC_BUF  = 1'b0,
    parameter logic        DAC_GA_N = 1'b1
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              sample_stb,
    input  logic              overrun_clr,
    output logic              busy,
    output logic              overrun,
    output logic              dac_cs_n,
    output logic              dac_sck,
    output logic              dac_sdi,
    output logic              dac_ld_n
);

    state_t             state, state_next;
    logic               tick, restart;
    logic [FRAME_W-1:0] sr, sr_next;
    logic [3:0]         bit_cnt, bit_next;
    logic               busy_next, ovr_next, cs_next, sck_next, sdi_next;
`ifdef DAC_LDAC_EN
    logic               ld_next;
`endif

    dac_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    assign restart = (state_next != state);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sr_next    = sr;
        bit_next   = bit_cnt;
        cs_next    = dac_cs_n;
        sck_next   = dac_sck;
        sdi_next   = dac_sdi;
`ifdef DAC_LDAC_EN
        ld_next    = dac_ld_n;
`endif
        case (state)
            IDLE: begin
                if (sample_stb) begin
                    sr_next    = build_frame(DAC_BUF, DAC_GA_N, data_in);
                    bit_next   = '0;
                    cs_next    = 1'b0;
                    sck_next   = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    sdi_next   = sr[FRAME_W-1];
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // dac_sck doubles as the phase flag: low half, then high half.
                if (tick) begin
                    if (!dac_sck) begin
                        sck_next = 1'b1;
                    end else begin
                        sck_next = 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state_next = STOP;
                        end else begin
                            bit_next = bit_cnt + 4'd1;
                            sr_next  = {sr[FRAME_W-2:0], 1'b0};
                            sdi_next = sr[FRAME_W-2];
                        end
                    end
                end
            end
            STOP: begin
                // First half keeps CS low, second half waits with CS high.
                if (tick) begin
                    if (!dac_cs_n) begin
                        cs_next = 1'b1;
                    end else begin
`ifdef DAC_LDAC_EN
                        ld_next    = 1'b0;
                        state_next = LDAC;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
`ifdef DAC_LDAC_EN
            LDAC: begin
                if (tick) begin
                    ld_next    = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
        if (sample_stb && state != IDLE) begin
            ovr_next = 1'b1;
        end else if (overrun_clr) begin
            ovr_next = 1'b0;
        end else begin
            ovr_next = overrun;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            dac_cs_n <= 1'b1;
            dac_sck  <= 1'b0;
            dac_sdi  <= 1'b0;
        end else begin
            sr       <= sr_next;
            bit_cnt  <= bit_next;
            busy     <= busy_next;
            overrun  <= ovr_next;
            dac_cs_n <= cs_next;
            dac_sck  <= sck_next;
            dac_sdi  <= sdi_next;
        end
    end

`ifdef DAC_LDAC_EN
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            dac_ld_n <= 1'b1;
        end else begin
            dac_ld_n <= ld_next;
        end
    end
`else
    assign dac_ld_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Scoreboard bench for dac_spi_serializer at CLK_DIV=16; honours DAC_LDAC_EN.
module tb_dac_spi_serializer;

    localparam int D        = 16;
    localparam int CS_LOW_T = 34 * D;
`ifdef DAC_LDAC_EN
    localparam int FRAME_T  = 36 * D;
    localparam int LD_EXP   = D;
    localparam logic LD_IDLE = 1'b1;
`else
    localparam int FRAME_T  = 35 * D;
    localparam int LD_EXP   = 35 * D;
    localparam logic LD_IDLE = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] data_in = '0;
    logic       sample_stb = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       busy, overrun, dac_cs_n, dac_sck, dac_sdi, dac_ld_n;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    int          cs_low = 0, rises = 0, rise_total = 0, busy_cnt = 0, ld_low = 0, ld_gap = 0;
    logic        ld_seen = 1'b0;
    logic [15:0] shreg = '0;
    logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0;

    dac_spi_serializer #(
        .CLK_DIV (D),
        .DAC_BUF (1'b0),
        .DAC_GA_N(1'b1)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .sample_stb (sample_stb),
        .overrun_clr(overrun_clr),
        .busy       (busy),
        .overrun    (overrun),
        .dac_cs_n   (dac_cs_n),
        .dac_sck    (dac_sck),
        .dac_sdi    (dac_sdi),
        .dac_ld_n   (dac_ld_n)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bench-side frame model: C=0, BUF=0, GA_N=1, SHDN=1, data, 2 zero bits.
    function automatic logic [15:0] model_frame(input logic [9:0] d);
        return {1'b0, 1'b0, 1'b1, 1'b1, d, 2'b00};
    endfunction

    always @(negedge sysclk) begin
        if (!rst_n) begin
            cs_low = 0; rises = 0; busy_cnt = 0; ld_low = 0; ld_gap = 0; ld_seen = 1'b0;
            shreg = '0; prev_sck = 1'b0; prev_cs = 1'b1; prev_busy = 1'b0;
        end else begin
            if (dac_sck && !prev_sck) begin
                shreg = {shreg[14:0], dac_sdi};
                rises++;
                rise_total++;
            end
            if (!dac_cs_n) cs_low++;
            if (busy) begin
                busy_cnt++;
                if (!dac_ld_n) ld_low++;
                if (dac_cs_n && dac_ld_n && !ld_seen) ld_gap++;
                if (!dac_ld_n) ld_seen = 1'b1;
            end
            if (!prev_cs && dac_cs_n) begin
                if (exp_q.size() == 0) check_eq("unexpected_frame", 1, 0);
                else check_eq("frame", shreg, exp_q.pop_front());
                check_eq("sck_rises", rises, 16);
                check_eq("cs_low_time", cs_low, CS_LOW_T);
                rises = 0; cs_low = 0;
            end
            if (prev_busy && !busy) begin
                check_eq("busy_time", busy_cnt, FRAME_T);
                check_eq("ld_low_time", ld_low, LD_EXP);
`ifdef DAC_LDAC_EN
                check_eq("ld_delay", ld_gap, D);
`endif
                busy_cnt = 0; ld_low = 0; ld_gap = 0; ld_seen = 1'b0;
            end
            prev_sck  = dac_sck;
            prev_cs   = dac_cs_n;
            prev_busy = busy;
        end
    end

    task automatic send(input logic [9:0] d);
        @(posedge sysclk); #1;
        data_in = d;
        sample_stb = 1'b1;
        exp_q.push_back(model_frame(d));
        @(posedge sysclk); #1;
        sample_stb = 1'b0;
        data_in = ~d;
        check_eq("accept_busy", busy, 1);
        check_eq("accept_cs", dac_cs_n, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge sysclk); #1;
            n++;
        end
        if (busy) check_eq("idle_timeout", busy, 0);
    endtask

    // Strobe in the very first cycle busy reads low after a frame.
    task automatic send_on_fall(input logic [9:0] d);
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge sysclk); #1;
            n++;
        end
        if (busy) check_eq("fall_timeout", busy, 0);
        data_in = d;
        sample_stb = 1'b1;
        exp_q.push_back(model_frame(d));
        @(posedge sysclk); #1;
        sample_stb = 1'b0;
        data_in = ~d;
        check_eq("fall_accept_cs", dac_cs_n, 0);
        check_eq("fall_accept_busy", busy, 1);
        check_eq("fall_no_overrun", overrun, 0);
    endtask

    initial begin
        logic [31:0] snap;
        repeat (4) @(posedge sysclk);
        #2 rst_n = 1'b1;
        @(posedge sysclk); #1;
        check_eq("rst_cs", dac_cs_n, 1);
        check_eq("rst_sck", dac_sck, 0);
        check_eq("rst_sdi", dac_sdi, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_ld", dac_ld_n, LD_IDLE);

        send(10'h200);
        wait_idle();

        send(10'h3FF);
        send_on_fall(10'h000);
        wait_idle();

        send(10'h2AA);
        repeat (99) @(posedge sysclk);
        #1;
        data_in = 10'h155;
        sample_stb = 1'b1;
        @(posedge sysclk); #1;
        sample_stb = 1'b0;
        check_eq("overrun_set", overrun, 1);
        sample_stb = 1'b1;
        overrun_clr = 1'b1;
        @(posedge sysclk); #1;
        sample_stb = 1'b0;
        overrun_clr = 1'b0;
        check_eq("overrun_set_wins", overrun, 1);
        overrun_clr = 1'b1;
        @(posedge sysclk); #1;
        overrun_clr = 1'b0;
        check_eq("overrun_clr", overrun, 0);
        wait_idle();

        send(10'h0F0);
        repeat (250) @(posedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_cs", dac_cs_n, 1);
        check_eq("midrst_sck", dac_sck, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ld", dac_ld_n, LD_IDLE);
        exp_q.delete();
        repeat (3) @(posedge sysclk);
        #2 rst_n = 1'b1;
        snap = rise_total;
        repeat (100) @(posedge sysclk);
        #1;
        check_eq("post_rst_no_sck", rise_total, snap);
        check_eq("post_rst_cs", dac_cs_n, 1);
        check_eq("post_rst_busy", busy, 0);

        send(10'h123);
        wait_idle();
        repeat (2) @(negedge sysclk);
        check_eq("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
